// File: rtl/decode_pkg.sv
// Shared decode types: control bundle, ALU operation codes and RV32I opcodes.
package decode_pkg;

    localparam int unsigned ILEN     = 32;
    localparam int unsigned ALU_OP_W = 5;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 5'd0;
    localparam alu_op_t ALU_SUB  = 5'd1;
    localparam alu_op_t ALU_SLL  = 5'd2;
    localparam alu_op_t ALU_SLT  = 5'd3;
    localparam alu_op_t ALU_SLTU = 5'd4;
    localparam alu_op_t ALU_XOR  = 5'd5;
    localparam alu_op_t ALU_SRL  = 5'd6;
    localparam alu_op_t ALU_SRA  = 5'd7;
    localparam alu_op_t ALU_OR   = 5'd8;
    localparam alu_op_t ALU_AND  = 5'd9;
    localparam alu_op_t ALU_EQ   = 5'd10;
    localparam alu_op_t ALU_JALR = 5'd11;
    localparam alu_op_t ALU_JAL  = 5'd12;
    localparam alu_op_t ALU_NONE = 5'd15;
    localparam alu_op_t ALU_MUL  = 5'd16;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // mux1_sel: 0 = rs2, 1 = imm as operand B.
    // mux2_sel: 0 = ALU, 1 = load data, 2 = pc+4 as writeback source.
    typedef struct packed {
        alu_op_t     alu_op;
        logic        mux1_sel;
        logic [1:0]  mux2_sel;
        logic        auipc;
        logic        jal;
        logic [3:0]  dwe;
        logic [3:0]  rf_we;
        logic        l_unsign;
        logic        is_branch;
        logic        is_cond_branch;
        logic        br_cond;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_NONE;
        return c;
    endfunction

    function automatic ctrl_t ctrl_illegal();
        ctrl_t c;
        c         = ctrl_idle();
        c.illegal = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/rv32_decode.sv
// Purely combinational RV32I instruction decoder.
// Optional M-extension decode enabled by defining RV32M_EN.
module rv32_decode
    import decode_pkg::*;
(
    input  logic [ILEN-1:0] idata,
    output ctrl_t           ctrl_c
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    ctrl_t       c;
    logic        ill;

    assign opcode = idata[6:0];
    assign funct3 = idata[14:12];
    assign funct7 = idata[31:25];

    assign imm_i = {{20{idata[31]}}, idata[31:20]};
    assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
    assign imm_b = {{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0};
    assign imm_u = {idata[31:12], 12'b0};
    assign imm_j = {{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};

    // Register fields are only reported for the operands the format really has.
    always_comb begin
        c        = '0;
        c.alu_op = ALU_NONE;
        ill      = 1'b0;
        case (opcode)
            OPC_LUI: begin
                c.alu_op   = ALU_ADD;
                c.mux1_sel = 1'b1;
                c.rf_we    = 4'hF;
                c.rd       = idata[11:7];
                c.imm      = imm_u;
            end
            OPC_AUIPC: begin
                c.alu_op   = ALU_ADD;
                c.mux1_sel = 1'b1;
                c.auipc    = 1'b1;
                c.rf_we    = 4'hF;
                c.rd       = idata[11:7];
                c.imm      = imm_u;
            end
            OPC_JAL: begin
                c.alu_op    = ALU_JAL;
                c.mux1_sel  = 1'b1;
                c.mux2_sel  = 2'd2;
                c.jal       = 1'b1;
                c.is_branch = 1'b1;
                c.rf_we     = 4'hF;
                c.rd        = idata[11:7];
                c.imm       = imm_j;
            end
            OPC_JALR: begin
                c.alu_op    = ALU_JALR;
                c.mux1_sel  = 1'b1;
                c.mux2_sel  = 2'd2;
                c.jal       = 1'b1;
                c.is_branch = 1'b1;
                c.rf_we     = 4'hF;
                c.rs1       = idata[19:15];
                c.rd        = idata[11:7];
                c.imm       = imm_i;
                ill         = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                c.is_branch      = 1'b1;
                c.is_cond_branch = 1'b1;
                c.rs1            = idata[19:15];
                c.rs2            = idata[24:20];
                c.imm            = imm_b;
                // br_cond is the ALU result value that makes the branch taken.
                case (funct3)
                    3'b000:  begin c.alu_op = ALU_EQ;   c.br_cond = 1'b1; end
                    3'b001:  begin c.alu_op = ALU_EQ;   c.br_cond = 1'b0; end
                    3'b100:  begin c.alu_op = ALU_SLT;  c.br_cond = 1'b1; end
                    3'b101:  begin c.alu_op = ALU_SLT;  c.br_cond = 1'b0; end
                    3'b110:  begin c.alu_op = ALU_SLTU; c.br_cond = 1'b1; end
                    3'b111:  begin c.alu_op = ALU_SLTU; c.br_cond = 1'b0; end
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                c.alu_op   = ALU_ADD;
                c.mux1_sel = 1'b1;
                c.mux2_sel = 2'd1;
                c.rf_we    = 4'hF;
                c.rs1      = idata[19:15];
                c.rd       = idata[11:7];
                c.imm      = imm_i;
                case (funct3)
                    3'b000, 3'b001, 3'b010: c.l_unsign = 1'b0;
                    3'b100, 3'b101:         c.l_unsign = 1'b1;
                    default:                ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                c.alu_op   = ALU_ADD;
                c.mux1_sel = 1'b1;
                c.rs1      = idata[19:15];
                c.rs2      = idata[24:20];
                c.imm      = imm_s;
                case (funct3)
                    3'b000:  c.dwe = 4'b0001;
                    3'b001:  c.dwe = 4'b0011;
                    3'b010:  c.dwe = 4'b1111;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                c.mux1_sel = 1'b1;
                c.rf_we    = 4'hF;
                c.rs1      = idata[19:15];
                c.rd       = idata[11:7];
                c.imm      = imm_i;
                case (funct3)
                    3'b000: c.alu_op = ALU_ADD;
                    3'b010: c.alu_op = ALU_SLT;
                    3'b011: c.alu_op = ALU_SLTU;
                    3'b100: c.alu_op = ALU_XOR;
                    3'b110: c.alu_op = ALU_OR;
                    3'b111: c.alu_op = ALU_AND;
                    3'b001: begin
                        c.alu_op = ALU_SLL;
                        ill      = (funct7 != F7_BASE);
                    end
                    default: begin
                        c.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        ill      = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                c.rf_we = 4'hF;
                c.rs1   = idata[19:15];
                c.rs2   = idata[24:20];
                c.rd    = idata[11:7];
                if (funct7 == F7_MULDIV) begin
`ifdef RV32M_EN
                    c.alu_op = ALU_MUL | alu_op_t'(funct3);
`else
                    ill = 1'b1;
`endif
                end else if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  c.alu_op = ALU_ADD;
                        3'b001:  c.alu_op = ALU_SLL;
                        3'b010:  c.alu_op = ALU_SLT;
                        3'b011:  c.alu_op = ALU_SLTU;
                        3'b100:  c.alu_op = ALU_XOR;
                        3'b101:  c.alu_op = ALU_SRL;
                        3'b110:  c.alu_op = ALU_OR;
                        default: c.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  c.alu_op = ALU_SUB;
                        3'b101:  c.alu_op = ALU_SRA;
                        default: ill = 1'b1;
                    endcase
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_FENCE: c.alu_op = ALU_NONE;
            default:   ill = 1'b1;
        endcase

        if (ill) begin
            c = ctrl_illegal();
        end
        if (c.rd == 5'd0) begin
            c.rf_we = 4'h0;
        end
    end

    assign ctrl_c = c;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: RV32I decoder feeding a QDEPTH-entry valid/ready output queue.
// Define RV32M_EN to enable M-extension decode.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned PC_W   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     idata,
    input  logic [PC_W-1:0] iaddr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output ctrl_t           out_ctrl,
    output logic [PC_W-1:0] out_pc
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;

    ctrl_t           dec_c;
    ctrl_t           ctrl_mem [QDEPTH];
    logic [PC_W-1:0] pc_mem   [QDEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full_c, empty_c, push_c, pop_c;

    rv32_decode u_decode (
        .idata  (idata),
        .ctrl_c (dec_c)
    );

    assign full_c    = (count == CW'(QDEPTH));
    assign empty_c   = (count == '0);
    assign in_ready  = !full_c || out_ready;
    assign out_valid = !empty_c;
    assign push_c    = in_valid && in_ready;
    assign pop_c     = out_valid && out_ready;

    // Pointers and occupancy; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are only observable through a valid count.
    always_ff @(posedge clk) begin
        if (push_c && !flush) begin
            ctrl_mem[wr_ptr] <= dec_c;
            pc_mem[wr_ptr]   <= iaddr;
        end
    end

    assign out_ctrl = empty_c ? ctrl_idle() : ctrl_mem[rd_ptr];
    assign out_pc   = empty_c ? '0 : pc_mem[rd_ptr];

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: table of instructions with hand-derived bundles.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int unsigned QDEPTH = 2;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned NI     = 15;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [PC_W-1:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     idata;
    logic [PC_W-1:0] iaddr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    ctrl_t           out_ctrl;
    logic [PC_W-1:0] out_pc;

    exp_t        sb[$];
    logic [31:0] instr [NI];
    ctrl_t       expc  [NI];
    logic [31:0] pc_ctr;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.QDEPTH(QDEPTH), .PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .idata     (idata),
        .iaddr     (iaddr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ctrl_t mk(input logic [4:0] alu, input logic m1, input logic [1:0] m2,
                                 input logic aui, input logic jl, input logic [3:0] dwe,
                                 input logic [3:0] rfwe, input logic lu, input logic br,
                                 input logic cbr, input logic brc, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
        ctrl_t c;
        c.alu_op = alu;   c.mux1_sel = m1;        c.mux2_sel = m2;
        c.auipc = aui;    c.jal = jl;             c.dwe = dwe;
        c.rf_we = rfwe;   c.l_unsign = lu;        c.is_branch = br;
        c.is_cond_branch = cbr; c.br_cond = brc;  c.rs1 = rs1;
        c.rs2 = rs2;      c.rd = rd;              c.imm = imm;
        c.illegal = 1'b0;
        return c;
    endfunction

    function automatic ctrl_t idle_exp();
        ctrl_t c;
        c = '0;
        c.alu_op = 5'd15;
        return c;
    endfunction

    function automatic ctrl_t ill_exp();
        ctrl_t c;
        c = idle_exp();
        c.illegal = 1'b1;
        return c;
    endfunction

    // One clock: drive at negedge, check settled outputs, then update the model.
    task automatic cycle(input logic iv, input int idx, input logic ordy, input logic fl);
        exp_t e;
        logic model_ready;
        @(negedge clk);
        in_valid  = iv;
        idata     = instr[idx];
        iaddr     = pc_ctr;
        out_ready = ordy;
        flush     = fl;
        #1;
        model_ready = (sb.size() < QDEPTH) || ordy;
        check("out_valid", out_valid, sb.size() != 0);
        check("count", dut.count, sb.size());
        check("in_ready", in_ready, model_ready);
        if (sb.size() != 0) begin
            check("out_ctrl", out_ctrl, sb[0].ctrl);
            check("out_pc", out_pc, sb[0].pc);
        end else begin
            check("idle_ctrl", out_ctrl, idle_exp());
            check("idle_pc", out_pc, 0);
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && ordy) void'(sb.pop_front());
            if (iv && model_ready) begin
                e.ctrl = expc[idx];
                e.pc   = pc_ctr;
                sb.push_back(e);
            end
        end
        pc_ctr = pc_ctr + 32'd4;
    endtask

    initial begin
        instr[0]  = 32'h00500093; expc[0]  = mk(5'd0, 1, 0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0, 1, 32'd5);
        instr[1]  = 32'h0020E463; expc[1]  = mk(5'd4, 0, 0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 1, 1, 2, 0, 32'd8);
        instr[2]  = 32'h022081B3;
`ifdef RV32M_EN
        expc[2] = mk(5'd16, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0, 1, 2, 3, 32'd0);
`else
        expc[2] = ill_exp();
`endif
        instr[3]  = 32'h123452B7; expc[3]  = mk(5'd0, 1, 0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0, 5, 32'h12345000);
        instr[4]  = 32'hFE20AE23; expc[4]  = mk(5'd0, 1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 2, 0, 32'hFFFFFFFC);
        instr[5]  = 32'h0030C383; expc[5]  = mk(5'd0, 1, 1, 0, 0, 4'h0, 4'hF, 1, 0, 0, 0, 1, 0, 7, 32'd3);
        instr[6]  = 32'hFF9FF0EF; expc[6]  = mk(5'd12, 1, 2, 0, 1, 4'h0, 4'hF, 0, 1, 0, 0, 0, 0, 1, 32'hFFFFFFF8);
        instr[7]  = 32'h00008067; expc[7]  = mk(5'd11, 1, 2, 0, 1, 4'h0, 4'h0, 0, 1, 0, 0, 1, 0, 0, 32'd0);
        instr[8]  = 32'h40628233; expc[8]  = mk(5'd1, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0, 5, 6, 4, 32'd0);
        instr[9]  = 32'h4034D413; expc[9]  = mk(5'd7, 1, 0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0, 9, 0, 8, 32'h403);
        instr[10] = 32'hFFFFFFFF; expc[10] = ill_exp();
        instr[11] = 32'h40001033; expc[11] = ill_exp();
        instr[12] = 32'h00000013; expc[12] = mk(5'd0, 1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
        instr[13] = 32'h0041D863; expc[13] = mk(5'd3, 0, 0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 0, 3, 4, 0, 32'd16);
        instr[14] = 32'h00001117; expc[14] = mk(5'd0, 1, 0, 1, 0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0, 2, 32'h1000);

        pc_ctr    = 32'h1000;
        reset     = 1'b0;
        in_valid  = 1'b0;
        idata     = '0;
        iaddr     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ctrl", out_ctrl, idle_exp());
        check("rst_pc", out_pc, 0);
        reset = 1'b1;

        // Streaming with a ready consumer: one-cycle latency per instruction.
        for (int i = 0; i < int'(NI); i++) cycle(1'b1, i, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 0, 1'b1, 1'b0);

        // Backpressure: fill, stall, then simultaneous push and pop when full.
        repeat (3) cycle(1'b1, 0, 1'b0, 1'b0);
        cycle(1'b1, 1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);

        // Flush with a concurrent push drops everything.
        repeat (2) cycle(1'b1, 2, 1'b0, 1'b0);
        cycle(1'b1, 3, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 0, 1'b1, 1'b0);

        // Asynchronous reset with entries queued.
        repeat (2) cycle(1'b1, 4, 1'b0, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_count", dut.count, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, NI - 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        for (int n = 0; n < 10 && sb.size() != 0; n++) cycle(1'b0, 0, 1'b1, 1'b0);
        check("drain", sb.size(), 0);
        cycle(1'b0, 0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, meaning output queue depth in entries (power of two, >= 2).
REQ-002 SHALL have parameter PC_W, default 32, meaning width of the pass-through instruction address.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  instruction word and address are present.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port idata  input  32  instruction word.
REQ-008 SHALL have port iaddr  input  PC_W  instruction address.
REQ-009 SHALL have port flush  input  1  discard all queued entries.
REQ-010 SHALL have port out_valid  output  1  decoded bundle is present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the bundle this cycle.
REQ-012 SHALL have port out_ctrl  output  ctrl_t  decoded control bundle.
REQ-013 SHALL have port out_pc  output  PC_W  address of the decoded instruction.

Function
REQ-014 SHALL decode RV32I to ctrl_t with fields alu_op[4:0], mux1_sel, mux2_sel[1:0], auipc, jal, dwe[3:0], rf_we[3:0], l_unsign, is_branch, is_cond_branch, br_cond, rs1, rs2, rd, imm[31:0], illegal.
REQ-015 SHALL use alu_op codes 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 eq, 11 jalr, 12 jal, 15 none.
REQ-016 SHALL sign-extend I/S/B/J immediates; B and J imm SHALL be byte offsets with imm[0]=0; U imm SHALL be idata[31:12]<<12.
REQ-017 SHALL encode branches as funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-018 SHALL force rf_we=0 whenever rd=0.
REQ-019 SHALL set illegal=1, alu_op=15 and all enables (rf_we, dwe, is_branch, jal, auipc) to 0 for any unsupported opcode/funct3/funct7.
REQ-020 SHALL accept an instruction when in_valid && in_ready, writing its decoded bundle and iaddr into the queue tail.
REQ-021 SHALL present an accepted instruction on out_* exactly one cycle after acceptance when the queue was empty.
REQ-022 SHALL drive in_ready = !full || out_ready; a simultaneous push and pop on a full queue SHALL succeed with count unchanged.
REQ-023 SHALL hold out_ctrl and out_pc stable while out_valid && !out_ready.
REQ-024 SHALL keep read/write pointers modulo QDEPTH and an occupancy counter of width clog2(QDEPTH)+1.
REQ-025 SHALL on flush empty the queue at the next edge, and SHALL drop any instruction accepted in the flush cycle.
REQ-026 SHALL preserve in-order delivery; no entry is lost or duplicated.

Reset
REQ-027 SHALL on reset low asynchronously clear pointers and count, forcing out_valid=0 and in_ready=1 (in_ready=1 while reset is low).
REQ-028 SHALL drive out_ctrl to all-zero with alu_op=15 and out_pc=0 while the queue is empty or in reset.
REQ-029 SHALL discard all queued entries on reset assertion mid-operation.

Configuration
REQ-030 SHALL with RV32M_EN defined decode funct7=0000001 R-type as alu_op 16-23 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
REQ-031 SHALL without RV32M_EN treat those encodings as illegal per REQ-019.

Structure
REQ-032 SHALL place ctrl_t struct, alu_op constants and opcode constants in shared package decode_pkg.
REQ-033 SHALL implement decoding in a purely combinational sub-module rv32_decode; queue and handshake live in decode_stage.

Verification
REQ-034 SHALL cover: idata=0x00500093 (addi x1,x0,5) accepted -> next cycle out_valid=1, alu_op=0, rd=1, imm=5, mux1_sel=1, rf_we=4'hF.
REQ-035 SHALL cover: idata=0x0020E463 (bltu x1,x2,8) -> alu_op=4, br_cond=1, is_cond_branch=1, imm=8, rf_we=0.
REQ-036 SHALL cover: out_ready=0, QDEPTH=2, three back-to-back valids -> in_ready=0 after two accepts; out_ready=1 with in_valid=1 -> push and pop same cycle, count stays 2.
REQ-037 SHALL cover: idata=0x022081B3 (mul x3,x1,x2) -> alu_op=16 with RV32M_EN, illegal=1 and alu_op=15 without.
REQ-038 SHALL cover: two entries queued, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0; reset low mid-stream -> out_valid=0 immediately, no stale entry after release.
